// File: rtl/uart_rx_frame_ctrl_if.sv
// rtl/uart_rx_frame_ctrl_if.sv - signal bundle between the UART receive frame controller and its environment
//
// Purpose: groups the line, configuration, sampler handshake and frame result
// signals of uart_rx_frame_ctrl so they travel as one port.
//
// Signals:
//   RX_In        serial line, idle high (already synchronized)
//   Prescale     oversampling ratio (8, 16 or 32), static during a frame
//   PAR_EN       parity bit present between data and stop
//   PAR_TYP      0 = even parity, 1 = odd parity
//   Sampled_Bit  majority-voted bit from the sampler
//   Data_Samp_En sampler enable, high while a frame is being received
//   Edge_Cnt     oversampling tick inside the current bit
//   P_DATA       last good received byte
//   Data_Valid   one-cycle pulse, good frame
//   Par_Err      one-cycle pulse, parity mismatch
//   Stp_Err      one-cycle pulse, stop bit sampled low
//
// Modports:
//   master  drives line/configuration/sampler, observes results
//   slave   the frame controller itself

interface uart_rx_frame_ctrl_if #(
  parameter int Prescale_Width = 6,
  parameter int Data_Width     = 8
) ();

  logic                      RX_In;
  logic [Prescale_Width-1:0] Prescale;
  logic                      PAR_EN;
  logic                      PAR_TYP;
  logic                      Sampled_Bit;
  logic                      Data_Samp_En;
  logic [Prescale_Width-1:0] Edge_Cnt;
  logic [Data_Width-1:0]     P_DATA;
  logic                      Data_Valid;
  logic                      Par_Err;
  logic                      Stp_Err;

  modport master (
    output RX_In,
    output Prescale,
    output PAR_EN,
    output PAR_TYP,
    output Sampled_Bit,
    input  Data_Samp_En,
    input  Edge_Cnt,
    input  P_DATA,
    input  Data_Valid,
    input  Par_Err,
    input  Stp_Err
  );

  modport slave (
    input  RX_In,
    input  Prescale,
    input  PAR_EN,
    input  PAR_TYP,
    input  Sampled_Bit,
    output Data_Samp_En,
    output Edge_Cnt,
    output P_DATA,
    output Data_Valid,
    output Par_Err,
    output Stp_Err
  );

endinterface

// File: rtl/uart_rx_frame_ctrl.sv
// rtl/uart_rx_frame_ctrl.sv - UART receive frame controller: start detect, bit timing, deserialize, parity/stop check
//
// Purpose: detects the start edge on RX_In, runs the per-bit oversampling tick
// counter that times the majority-vote sampler, shifts in the voted data bits
// LSB-first, checks the optional parity bit and the stop bit, and reports the
// frame outcome with one-cycle pulses.
//
// Ports:
//   clk   receiver oversampling clock
//   rst   synchronous active-low reset
//   bus   uart_rx_frame_ctrl_if.slave
//           in : RX_In, Prescale, PAR_EN, PAR_TYP, Sampled_Bit
//           out: Data_Samp_En, Edge_Cnt, P_DATA, Data_Valid, Par_Err, Stp_Err
//
// All outputs are registered.

module uart_rx_frame_ctrl #(
  parameter int Prescale_Width = 6,
  parameter int Data_Width     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  uart_rx_frame_ctrl_if.slave   bus
);

  localparam int BitCntWidth = $clog2(Data_Width + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                    r_state;
  logic [Prescale_Width-1:0] r_edge_cnt;
  logic [BitCntWidth-1:0]    r_bit_cnt;
  logic [Data_Width-1:0]     r_shift;
  logic [Data_Width-1:0]     r_p_data;
  logic                      r_samp_en;
  logic                      r_data_valid;
  logic                      r_par_err;
  logic                      r_stp_err;
  // Remembers a parity failure until the stop bit decides the frame outcome.
  logic                      r_par_bad;

  logic [Prescale_Width-1:0] w_last_tick;
  logic                      w_bit_end;
  logic [Prescale_Width-1:0] w_edge_next;
  logic                      w_par_exp;
  logic                      w_last_data_bit;

  assign w_last_tick = bus.Prescale - Prescale_Width'(1);

  // ">=" rather than "==" so an illegal or changed Prescale can never leave
  // the counter above its wrap point and stall the frame.
  assign w_bit_end   = (r_edge_cnt >= w_last_tick);
  assign w_edge_next = w_bit_end ? '0 : r_edge_cnt + Prescale_Width'(1);

  assign w_par_exp       = (^r_shift) ^ bus.PAR_TYP;
  assign w_last_data_bit = (r_bit_cnt == BitCntWidth'(Data_Width - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_edge_cnt   <= '0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_p_data     <= '0;
      r_samp_en    <= 1'b0;
      r_data_valid <= 1'b0;
      r_par_err    <= 1'b0;
      r_stp_err    <= 1'b0;
      r_par_bad    <= 1'b0;
    end else begin
      // Result flags are single-cycle pulses.
      r_data_valid <= 1'b0;
      r_par_err    <= 1'b0;
      r_stp_err    <= 1'b0;

      case (r_state)
        IDLE: begin
          r_edge_cnt <= '0;
          if (!bus.RX_In) begin
            r_state   <= START;
            r_samp_en <= 1'b1;
          end else begin
            r_samp_en <= 1'b0;
          end
        end

        START: begin
          r_edge_cnt <= w_edge_next;
          if (w_bit_end) begin
            if (!bus.Sampled_Bit) begin
              r_state   <= DATA;
              r_bit_cnt <= '0;
              r_par_bad <= 1'b0;
            end else begin
              // Start bit did not hold low: treat as line glitch, no error.
              r_state   <= IDLE;
              r_samp_en <= 1'b0;
            end
          end
        end

        DATA: begin
          r_edge_cnt <= w_edge_next;
          if (w_bit_end) begin
            // Insert at the MSB so the first received bit ends at bit 0.
            r_shift   <= {bus.Sampled_Bit, r_shift[Data_Width-1:1]};
            r_bit_cnt <= r_bit_cnt + BitCntWidth'(1);
            if (w_last_data_bit) begin
              r_state <= bus.PAR_EN ? PARITY : STOP;
            end
          end
        end

        PARITY: begin
          r_edge_cnt <= w_edge_next;
          if (w_bit_end) begin
            if (bus.Sampled_Bit != w_par_exp) begin
              r_par_err <= 1'b1;
              r_par_bad <= 1'b1;
            end
            r_state <= STOP;
          end
        end

        STOP: begin
          r_edge_cnt <= w_edge_next;
          if (w_bit_end) begin
            r_state   <= IDLE;
            r_samp_en <= 1'b0;
            if (!bus.Sampled_Bit) begin
              r_stp_err <= 1'b1;
            end else if (!r_par_bad) begin
              r_data_valid <= 1'b1;
              r_p_data     <= r_shift;
            end
          end
        end

        default: begin
          r_state    <= IDLE;
          r_edge_cnt <= '0;
          r_samp_en  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Data_Samp_En = r_samp_en;
  assign bus.Edge_Cnt     = r_edge_cnt;
  assign bus.P_DATA       = r_p_data;
  assign bus.Data_Valid   = r_data_valid;
  assign bus.Par_Err      = r_par_err;
  assign bus.Stp_Err      = r_stp_err;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb/tb_uart_rx_frame_ctrl.sv - scoreboard bench for uart_rx_frame_ctrl

module tb_uart_rx_frame_ctrl;

  localparam int K_VALID = 0;
  localparam int K_PAR   = 1;
  localparam int K_STP   = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_frame_ctrl_if #(.Prescale_Width(6), .Data_Width(8)) bus ();

  uart_rx_frame_ctrl #(.Prescale_Width(6), .Data_Width(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  logic mon_en = 1'b0;

  typedef struct {
    int         kind;
    logic [7:0] pdata;
    int         at;
  } exp_t;
  exp_t sb[$];

  // Reference model state: last byte delivered and the cycle the receiver
  // is next able to see a start edge.
  logic [7:0] last_good = 8'h00;
  int         busy_until = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void expect_pulse(input int kind, input logic [7:0] pd, input int at);
    exp_t e;
    e.kind  = kind;
    e.pdata = pd;
    e.at    = at;
    sb.push_back(e);
  endfunction

  // Monitor: compares every result pulse against the scoreboard.
  always @(negedge clk) begin
    int   npulse;
    int   kind;
    exp_t e;
    if (mon_en) begin
      npulse = int'(bus.Data_Valid) + int'(bus.Par_Err) + int'(bus.Stp_Err);
      checks++;
      if (npulse > 1) begin
        errors++;
        $display("FAIL flags_exclusive: actual=%0d pulses expected<=1 (cycle %0d)", npulse, cyc);
      end
      checks++;
      if (int'(bus.Edge_Cnt) >= int'(bus.Prescale)) begin
        errors++;
        $display("FAIL edge_cnt_bound: actual=%0d expected<%0d (cycle %0d)", bus.Edge_Cnt, bus.Prescale, cyc);
      end
      if (npulse > 0) begin
        kind = bus.Data_Valid ? K_VALID : (bus.Par_Err ? K_PAR : K_STP);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: actual kind=%0d expected none (cycle %0d)", kind, cyc);
        end else begin
          e = sb.pop_front();
          chk("pulse_kind", kind, e.kind);
          chk("pulse_p_data", int'(bus.P_DATA), int'(e.pdata));
          chk("pulse_cycle", cyc, e.at);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.RX_In = 1'b1;
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_p_data"},   int'(bus.P_DATA), 0);
    chk({tag, "_edge_cnt"}, int'(bus.Edge_Cnt), 0);
    chk({tag, "_samp_en"},  int'(bus.Data_Samp_En), 0);
    chk({tag, "_dv"},       int'(bus.Data_Valid), 0);
    chk({tag, "_par_err"},  int'(bus.Par_Err), 0);
    chk({tag, "_stp_err"},  int'(bus.Stp_Err), 0);
  endtask

  // Drives one frame on the line; Sampled_Bit follows an ideal sampler that
  // latches the line bit at mid-bit. rst_bit >= 0 pulses reset in the middle
  // of that line bit (0 = start bit) and abandons the frame.
  task automatic send_frame(input int p, input logic pe, input logic typ, input logic [7:0] d,
                            input logic par_v, input logic stop_v, input int rst_bit);
    logic [10:0] bits;
    int          nb;
    int          n;
    int          s;
    int          done_at;
    logic        bad;
    bits       = '1;
    bits[0]    = 1'b0;
    bits[8:1]  = d;
    nb         = pe ? 11 : 10;
    if (pe) bits[9] = par_v;
    bits[nb-1] = stop_v;
    for (int k = 0; k < nb; k++) begin
      for (int j = 0; j < p; j++) begin
        @(negedge clk);
        if (k == 0 && j == 0) begin
          n            = cyc;
          bus.Prescale = 6'(p);
          bus.PAR_EN   = pe;
          bus.PAR_TYP  = typ;
          if (rst_bit < 0) begin
            s       = (n > busy_until) ? n : busy_until;
            done_at = s + 1 + nb * p;
            bad     = 1'b0;
            if (pe && (par_v != ((^d) ^ typ))) begin
              expect_pulse(K_PAR, last_good, s + 1 + 10 * p);
              bad = 1'b1;
            end
            if (!stop_v) begin
              expect_pulse(K_STP, last_good, done_at);
              bad = 1'b1;
            end
            if (!bad) begin
              last_good = d;
              expect_pulse(K_VALID, d, done_at);
            end
            busy_until = done_at;
          end
        end
        if (rst_bit == k && j == p / 2) begin
          rst = 1'b0;
          @(negedge clk);
          rst       = 1'b1;
          bus.RX_In = 1'b1;
          check_reset_values("midframe_reset");
          last_good  = 8'h00;
          busy_until = cyc;
          return;
        end
        bus.RX_In = bits[k];
        if (j == p / 2) bus.Sampled_Bit = bits[k];
      end
    end
  endtask

  task automatic glitch(input int p);
    int n;
    int s;
    @(negedge clk);
    n               = cyc;
    bus.Prescale    = 6'(p);
    bus.RX_In       = 1'b0;
    bus.Sampled_Bit = 1'b1;
    @(negedge clk);
    bus.RX_In = 1'b0;
    @(negedge clk);
    bus.RX_In = 1'b1;
    s          = (n > busy_until) ? n : busy_until;
    busy_until = s + p + 1;
    while (cyc < s + p) @(negedge clk);
    chk("glitch_last_tick", int'(bus.Edge_Cnt), p - 1);
    chk("glitch_samp_en_start", int'(bus.Data_Samp_En), 1);
    @(negedge clk);
    chk("glitch_back_idle_samp_en", int'(bus.Data_Samp_En), 0);
    chk("glitch_back_idle_edge", int'(bus.Edge_Cnt), 0);
  endtask

  initial begin
    int         p;
    logic       pe;
    logic       typ;
    logic [7:0] d;
    logic       par_v;
    logic       stop_v;

    bus.RX_In       = 1'b1;
    bus.Sampled_Bit = 1'b1;
    bus.Prescale    = 6'd8;
    bus.PAR_EN      = 1'b0;
    bus.PAR_TYP     = 1'b0;
    rst             = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst    = 1'b1;
    mon_en = 1'b1;
    busy_until = cyc;
    idle(4);

    // Good frame with even parity.
    send_frame(8, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b1, -1);
    idle(3);
    // Odd parity expected, parity bit sent 0.
    send_frame(8, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b1, -1);
    idle(3);
    // Stop bit low.
    send_frame(16, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, -1);
    idle(32);
    chk("stp_err_idle_samp_en", int'(bus.Data_Samp_En), 0);
    chk("stp_err_idle_edge", int'(bus.Edge_Cnt), 0);
    // Start glitch followed by a real frame.
    glitch(8);
    idle(4);
    send_frame(8, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, -1);
    idle(2);
    // Back-to-back frames, no line gap.
    send_frame(32, 1'b0, 1'b0, 8'h01, 1'b0, 1'b1, -1);
    send_frame(32, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, -1);
    idle(3);
    // Reset during data bit 4, then a clean frame.
    send_frame(8, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1, 5);
    idle(20);
    send_frame(8, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b1, -1);
    idle(3);

    // Randomized frames.
    for (int i = 0; i < 16; i++) begin
      p      = 8 << $urandom_range(0, 2);
      pe     = 1'($urandom_range(0, 1));
      typ    = 1'($urandom_range(0, 1));
      d      = 8'($urandom);
      par_v  = (^d) ^ typ ^ ($urandom_range(0, 4) == 0);
      stop_v = ($urandom_range(0, 5) != 0);
      send_frame(p, pe, typ, d, par_v, stop_v, -1);
      idle($urandom_range(1, 4));
    end

    for (int i = 0; i < 3000 && sb.size() > 0; i++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: actual=%0d pending expected=0", sb.size());
    end
    idle(40);
    chk("final_idle_samp_en", int'(bus.Data_Samp_En), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
